// File: rtl/prio_enc_stream.sv
// prio_enc_stream: captures a request vector and streams the index of each set bit, one per beat.
// Latency: first beat the cycle after accept; n set bits take n beats, an all-zero vector one beat.
// Backpressure: out_ready low freezes all state; in_ready only in IDLE or on a consumed last beat.
// Option: define PRIO_ENC_STREAM_RR_EN for rotating priority from a persistent ptr (default: MSB first).
module prio_enc_stream #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] req_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    NONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [IDX_W-1:0]   grant;
  logic               single;
  logic               accept;

  // One bit left means the current beat closes the vector.
  assign single = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
  assign accept = in_valid && in_ready;

  // in_ready opens when the last beat is consumed, so vectors flow back to back.
  assign in_ready = (state_q == IDLE) || (out_valid && out_ready && out_last);

`ifdef PRIO_ENC_STREAM_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Grant: first set bit searching downward from ptr inclusive, wrapping 0 -> WIDTH-1.
  // Iterating farthest-first and overwriting leaves the nearest hit in grant.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] p;
    grant = '0;
    pos   = 0;
    p     = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      pos = int'(ptr_q) - j;
      if (pos < 0) pos = pos + WIDTH;
      p = IDX_W'(pos);
      if (pend_q[p]) grant = p;
    end
  end

  // Pointer moves just below each consumed grant; NONE beats leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == SERVE && out_ready)
      ptr_d = (grant == '0) ? IDX_W'(WIDTH - 1) : grant - IDX_W'(1);
  end

  // Pointer register persists across vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(WIDTH - 1);
    else        ptr_q <= ptr_d;
  end
`else
  // Grant: highest set bit of pend (later loop hits override lower ones).
  always_comb begin
    grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) grant = IDX_W'(i);
    end
  end
`endif

  // State and pending-bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: consume the current beat, then let a same-edge accept override.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      SERVE: begin
        if (out_ready) begin
          pend_d = pend_q & ~(WIDTH'(1) << grant);
          if (single) state_d = IDLE;
        end
      end
      NONE: begin
        if (out_ready) state_d = IDLE;
      end
      IDLE:    ;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pend_d  = req_i;
      state_d = (req_i != '0) ? SERVE : NONE;
    end
  end

  // Outputs depend on registered state and pend only.
  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_none  = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      SERVE: begin
        out_valid = 1'b1;
        out_idx   = grant;
        out_last  = single;
      end
      NONE: begin
        out_valid = 1'b1;
        out_none  = 1'b1;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Directed bench for prio_enc_stream: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
// Inputs change and outputs are checked just after the falling edge; each step is one rising edge.
// The rotating-priority scenarios run when PRIO_ENC_STREAM_RR_EN is defined.
module tb_prio_enc_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, none4, last4;
  logic [3:0] req4 = '0;
  logic [1:0] idx4;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b1, none8, last8;
  logic [7:0] req8 = '0;
  logic [2:0] idx8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  prio_enc_stream #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .req_i(req4),
    .out_valid(ov4), .out_ready(or4), .out_idx(idx4), .out_none(none4), .out_last(last4)
  );

  prio_enc_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .req_i(req8),
    .out_valid(ov8), .out_ready(or8), .out_idx(idx8), .out_none(none8), .out_last(last8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic beat4(input string tag, input int idx, input int last, input int none, input int rdy);
    chk({tag, ".vld"},  int'(ov4),   1);
    chk({tag, ".idx"},  int'(idx4),  idx);
    chk({tag, ".last"}, int'(last4), last);
    chk({tag, ".none"}, int'(none4), none);
    chk({tag, ".rdy"},  int'(ir4),   rdy);
  endtask

  task automatic beat8(input string tag, input int idx, input int last, input int none, input int rdy);
    chk({tag, ".vld"},  int'(ov8),   1);
    chk({tag, ".idx"},  int'(idx8),  idx);
    chk({tag, ".last"}, int'(last8), last);
    chk({tag, ".none"}, int'(none8), none);
    chk({tag, ".rdy"},  int'(ir8),   rdy);
  endtask

  task automatic idle4(input string tag);
    chk({tag, ".vld"}, int'(ov4), 0);
    chk({tag, ".rdy"}, int'(ir4), 1);
  endtask

  task automatic idle8(input string tag);
    chk({tag, ".vld"}, int'(ov8), 0);
    chk({tag, ".rdy"}, int'(ir8), 1);
  endtask

  // Present one vector to dut4 for a single accept edge.
  task automatic send4(input logic [3:0] v);
    iv4 = 1'b1; req4 = v;
    #1;
    chk("send4.rdy", int'(ir4), 1);
    step();
    iv4 = 1'b0; req4 = 4'hF;
    #1;
  endtask

  task automatic send8(input logic [7:0] v);
    iv8 = 1'b1; req8 = v;
    #1;
    chk("send8.rdy", int'(ir8), 1);
    step();
    iv8 = 1'b0; req8 = 8'hFF;
    #1;
  endtask

  initial begin
    #1;
    chk("rst4.vld",  int'(ov4),   0);
    chk("rst4.rdy",  int'(ir4),   1);
    chk("rst4.idx",  int'(idx4),  0);
    chk("rst4.none", int'(none4), 0);
    chk("rst4.last", int'(last4), 0);
    chk("rst8.vld",  int'(ov8),   0);
    chk("rst8.rdy",  int'(ir8),   1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    idle4("post_rst4");

`ifndef PRIO_ENC_STREAM_RR_EN
    // 4'b1011 drains 3, 1, 0 on consecutive cycles.
    send4(4'b1011);
    beat4("b1011.i3", 3, 0, 0, 0);
    step();
    beat4("b1011.i1", 1, 0, 0, 0);
    step();
    beat4("b1011.i0", 0, 1, 0, 1);
    step();
    idle4("b1011.end");

    // All-zero vector: one NONE beat.
    send4(4'b0000);
    beat4("zero", 0, 1, 1, 1);
    step();
    idle4("zero.end");

    // Only bit 0.
    send4(4'b0001);
    beat4("bit0", 0, 1, 0, 1);
    step();
    idle4("bit0.end");

    // Back to back: second vector accepted on the first vector's last beat.
    iv4 = 1'b1; req4 = 4'b0100;
    #1;
    chk("b2b.rdy0", int'(ir4), 1);
    step();
    req4 = 4'b0010;
    #1;
    beat4("b2b.i2", 2, 1, 0, 1);
    step();
    iv4 = 1'b0;
    #1;
    beat4("b2b.i1", 1, 1, 0, 1);
    step();
    idle4("b2b.end");

    // All ones: WIDTH beats, last only on index 0.
    send4(4'b1111);
    for (int i = 3; i >= 0; i--) begin
      beat4("ones", i, (i == 0) ? 1 : 0, 0, (i == 0) ? 1 : 0);
      step();
    end
    idle4("ones.end");

    // Backpressure on 8'h81; a vector offered while stalled must be ignored.
    send8(8'h81);
    or8 = 1'b0;
    iv8 = 1'b1; req8 = 8'h3C;
    #1;
    for (int c = 0; c < 5; c++) begin
      beat8("stall", 7, 0, 0, 0);
      step();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    #1;
    beat8("bp.i7", 7, 0, 0, 0);
    step();
    beat8("bp.i0", 0, 1, 0, 1);
    step();
    idle8("bp.end");

    // Reset mid-vector after three consumed beats of 8'hFF.
    send8(8'hFF);
    beat8("ff.i7", 7, 0, 0, 0);
    step();
    beat8("ff.i6", 6, 0, 0, 0);
    step();
    beat8("ff.i5", 5, 0, 0, 0);
    step();
    beat8("ff.i4", 4, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst.vld",  int'(ov8),   0);
    chk("arst.idx",  int'(idx8),  0);
    chk("arst.last", int'(last8), 0);
    chk("arst.rdy",  int'(ir8),   1);
    rst_n = 1'b1;
    send8(8'h10);
    beat8("after_rst.i4", 4, 1, 0, 1);
    step();
    idle8("after_rst.end");
`else
    // Rotating priority: ptr starts at 3.
    send4(4'b1111);
    beat4("rr1111.i3", 3, 0, 0, 0);
    step();
    beat4("rr1111.i2", 2, 0, 0, 0);
    step();
    beat4("rr1111.i1", 1, 0, 0, 0);
    step();
    beat4("rr1111.i0", 0, 1, 0, 1);
    step();
    idle4("rr1111.end");

    // ptr wrapped back to 3.
    send4(4'b1010);
    beat4("rr1010a.i3", 3, 0, 0, 0);
    step();
    beat4("rr1010a.i1", 1, 1, 0, 1);
    step();
    idle4("rr1010a.end");

    // ptr is now 0; granting bit 2 moves it to 1.
    send4(4'b0100);
    beat4("rr0100.i2", 2, 1, 0, 1);
    step();

    // From ptr=1, 4'b1010 grants 1 then wraps to 3.
    send4(4'b1010);
    beat4("rrwrap.i1", 1, 0, 0, 0);
    step();
    beat4("rrwrap.i3", 3, 1, 0, 1);
    step();
    idle4("rrwrap.end");

    // A NONE beat leaves ptr alone (ptr=2 after granting 3).
    send4(4'b0000);
    beat4("rrzero", 0, 1, 1, 1);
    step();
    send4(4'b1001);
    beat4("rr1001.i0", 0, 0, 0, 0);
    step();
    beat4("rr1001.i3", 3, 1, 0, 1);
    step();
    idle4("rr1001.end");

    send8(8'h10);
    beat8("rr8.i4", 4, 1, 0, 1);
    step();
    idle8("rr8.end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
